// File: rtl/eth_frame_match_pkg.sv
// Shared types and constants for the Ethernet frame match logger:
// log-entry layout, matcher state encoding and field widths.
package eth_frame_match_pkg;

    localparam int TIME_W       = 64;
    localparam int LEN_W        = 16;
    localparam int MAX_PATTERNS = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } match_state_t;

    // The match vector is sized for the largest supported pattern count;
    // the top level only fills and reads the low C_NUM_PATTERNS bits.
    typedef struct packed {
        logic [TIME_W-1:0]       stamp;
        logic [MAX_PATTERNS-1:0] match;
        logic [LEN_W-1:0]        length;
        logic                    bad;
    } log_entry_t;

    // Select/index ports need at least one bit even when only one
    // pattern or one compared byte exists.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/eth_match_log_fifo.sv
// Single-clock first-word-fall-through FIFO holding log entries.
// A push while full is accepted only when a pop happens in the same cycle.
module eth_match_log_fifo
    import eth_frame_match_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type T_ENTRY = log_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  T_ENTRY push_data,
    output logic   full,
    input  logic   pop,
    output logic   valid,
    output T_ENTRY pop_data
);

    localparam int AW = $clog2(DEPTH);

    T_ENTRY           mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign valid    = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && valid;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = valid ? mem[rd_ptr] : '0;

    // Storage array is written without reset; the output is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/eth_frame_match_logger.sv
// Ethernet frame matcher and logger: compares the first C_PATTERN_LEN bytes
// of each frame against masked patterns and logs timestamp, match vector,
// length and bad flag of matching frames into a FIFO.
// Optional build macro ETH_FRAME_MATCH_LOGGER_DROP_BAD_EN discards frames
// flagged bad on their last beat and ties log_bad to 0.
module eth_frame_match_logger
    import eth_frame_match_pkg::*;
#(
    parameter int C_NUM_PATTERNS = 4,
    parameter int C_PATTERN_LEN  = 32,
    parameter int C_LOG_DEPTH    = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [7:0]                              s_axis_tdata,
    input  logic                                    s_axis_tuser,
    input  logic                                    s_axis_tlast,
    input  logic                                    s_axis_tvalid,
    input  logic                                    cfg_we,
    input  logic [clog2_min1(C_NUM_PATTERNS)-1:0]   cfg_pattern,
    input  logic [clog2_min1(C_PATTERN_LEN)-1:0]    cfg_index,
    input  logic [7:0]                              cfg_data,
    input  logic                                    cfg_mask,
    input  logic [C_NUM_PATTERNS-1:0]               match_en,
    input  logic [TIME_W-1:0]                       current_time,
    output logic                                    log_valid,
    input  logic                                    log_ready,
    output logic [TIME_W-1:0]                       log_time,
    output logic [C_NUM_PATTERNS-1:0]               log_match,
    output logic [LEN_W-1:0]                        log_length,
    output logic                                    log_bad,
    output logic [15:0]                             log_overflow
);

    localparam int                IW   = clog2_min1(C_PATTERN_LEN);
    localparam logic [LEN_W-1:0]  PLEN = LEN_W'(C_PATTERN_LEN);

    logic [7:0]                pattern [C_NUM_PATTERNS][C_PATTERN_LEN];
    logic                      mask    [C_NUM_PATTERNS][C_PATTERN_LEN];

    match_state_t              state;
    logic [LEN_W-1:0]          byte_cnt;
    logic [C_NUM_PATTERNS-1:0] flags;
    logic [TIME_W-1:0]         time_reg;
    logic                      skip;

    logic                      first_beat;
    logic                      beat;
    logic [LEN_W-1:0]          cur_cnt;
    logic [LEN_W-1:0]          new_cnt;
    logic [IW-1:0]             idx;
    logic [C_NUM_PATTERNS-1:0] flags_next;
    logic [C_NUM_PATTERNS-1:0] result;
    logic                      push;
    log_entry_t                entry;
    log_entry_t                fifo_out;
    logic                      fifo_full;
    logic                      unused_fifo_bits;

    assign first_beat = (state == ST_IDLE);
    assign beat       = s_axis_tvalid && !skip;
    assign cur_cnt    = first_beat ? '0 : byte_cnt;
    assign new_cnt    = (cur_cnt == '1) ? cur_cnt : cur_cnt + 1'b1;
    assign idx        = cur_cnt[IW-1:0];

    // Pattern byte/mask registers; a write is visible to compares next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < C_NUM_PATTERNS; p++) begin
                for (int i = 0; i < C_PATTERN_LEN; i++) begin
                    pattern[p][i] <= '0;
                    mask[p][i]    <= 1'b0;
                end
            end
        end else if (cfg_we && (int'(cfg_pattern) < C_NUM_PATTERNS)
                            && (int'(cfg_index) < C_PATTERN_LEN)) begin
            pattern[cfg_pattern][cfg_index] <= cfg_data;
            mask[cfg_pattern][cfg_index]    <= cfg_mask;
        end
    end

    // Per-beat compare: flags restart at all-ones on the first beat of a frame.
    always_comb begin
        flags_next = first_beat ? '1 : flags;
        if (cur_cnt < PLEN) begin
            for (int p = 0; p < C_NUM_PATTERNS; p++) begin
                if (mask[p][idx] && (s_axis_tdata != pattern[p][idx])) begin
                    flags_next[p] = 1'b0;
                end
            end
        end
        result = flags_next & match_en & {C_NUM_PATTERNS{new_cnt >= PLEN}};
    end

    // Log entry assembled on the last beat; the first beat's time is used directly.
    always_comb begin
        entry                          = '0;
        entry.stamp                    = first_beat ? current_time : time_reg;
        entry.match[C_NUM_PATTERNS-1:0] = result;
        entry.length                   = new_cnt;
        entry.bad                      = s_axis_tuser;
    end

`ifdef ETH_FRAME_MATCH_LOGGER_DROP_BAD_EN
    assign push             = beat && s_axis_tlast && (|result) && !s_axis_tuser;
    assign log_bad          = 1'b0;
    assign unused_fifo_bits = ^{fifo_out.match, fifo_out.bad};
`else
    assign push             = beat && s_axis_tlast && (|result);
    assign log_bad          = fifo_out.bad;
    assign unused_fifo_bits = ^fifo_out.match;
`endif

    // Matcher FSM; a reset landing mid-frame arms skip so the frame tail is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            flags    <= '0;
            time_reg <= '0;
            skip     <= (s_axis_tvalid && !s_axis_tlast)
                     || ((state == ST_FRAME || skip) && !(s_axis_tvalid && s_axis_tlast));
        end else if (s_axis_tvalid) begin
            if (skip) begin
                if (s_axis_tlast) begin
                    skip <= 1'b0;
                end
            end else if (s_axis_tlast) begin
                state    <= ST_IDLE;
                byte_cnt <= '0;
            end else begin
                state    <= ST_FRAME;
                byte_cnt <= new_cnt;
                flags    <= flags_next;
                if (first_beat) begin
                    time_reg <= current_time;
                end
            end
        end
    end

    // Dropped-entry counter: a full FIFO only rejects when nothing pops that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            log_overflow <= '0;
        end else if (push && fifo_full && !log_ready && (log_overflow != 16'hFFFF)) begin
            log_overflow <= log_overflow + 1'b1;
        end
    end

    eth_match_log_fifo #(
        .DEPTH   (C_LOG_DEPTH),
        .T_ENTRY (log_entry_t)
    ) u_log_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (entry),
        .full      (fifo_full),
        .pop       (log_ready),
        .valid     (log_valid),
        .pop_data  (fifo_out)
    );

    assign log_time   = fifo_out.stamp;
    assign log_match  = fifo_out.match[C_NUM_PATTERNS-1:0];
    assign log_length = fifo_out.length;

endmodule
